// File: rtl/axil_sram_v2_pkg.sv
// rtl/axil_sram_v2_pkg.sv - shared response codes, default sizes and grant type for axil_sram_v2
//
// Purpose: constants shared by the AXI-Lite SRAM top and its storage.
// Contents: RESP_OKAY / RESP_SLVERR response codes, DEF_DATA_W / DEF_DEPTH
//           defaults, grant_e (which request class owns the memory port).
package axil_sram_v2_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 4096;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

endpackage

// File: rtl/axil_sram_v2_sp_ram.sv
// rtl/axil_sram_v2_sp_ram.sv - single-port RAM with byte write mask and registered read
//
// Purpose: storage behind axil_sram_v2. One access per cycle; a write (any
//          i_we bit set) updates the selected bytes, a read (i_en with i_we=0)
//          loads o_rdata on the next edge. o_rdata only changes on reads.
// Ports:   clk      - rising-edge clock
//          i_en     - access enable
//          i_we     - byte write mask, DATA_W/8 bits
//          i_addr   - word index, log2(DEPTH) bits
//          i_wdata  - write data, DATA_W bits
//          o_rdata  - registered read data, DATA_W bits
// Define SP_RAM_FPGA to steer the array into block RAM on FPGA targets.
module sp_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4096
) (
  input  logic                       clk,
  input  logic                       i_en,
  input  logic [DATA_W/8-1:0]        i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_addr,
  input  logic [DATA_W-1:0]          i_wdata,
  output logic [DATA_W-1:0]          o_rdata
);

`ifdef SP_RAM_FPGA
  (* ram_style = "block" *) logic [DATA_W-1:0] r_mem [DEPTH];
`else
  logic [DATA_W-1:0] r_mem [DEPTH];
`endif

  logic [DATA_W-1:0] r_rdata;

  // Contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (|i_we) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (i_we[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axil_sram_v2.sv
// rtl/axil_sram_v2.sv - AXI-Lite slave fronting a single-port SRAM with round-robin R/W arbitration
//
// Purpose: AXI-Lite memory. AW and W land in independent one-entry holders;
//          a write fires once both are available and B is free, a read fires
//          on the AR handshake when R is free. Contention for the single RAM
//          port alternates between reads and writes, writes first after reset.
//          Addresses above the word-index field answer SLVERR with no effect.
// Ports:   clk, rst_n (async active-low)
//          sram_axi_aw*  - write address channel (awready = AW holder empty)
//          sram_axi_w*   - write data channel (wready = W holder empty)
//          sram_axi_b*   - write response channel
//          sram_axi_ar*  - read address channel (arready = read grant)
//          sram_axi_r*   - read data channel, one-cycle latency
module axil_sram_v2
  import axil_sram_v2_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   sram_axi_awaddr,
  input  logic                sram_axi_awvalid,
  output logic                sram_axi_awready,
  input  logic [DATA_W-1:0]   sram_axi_wdata,
  input  logic [DATA_W/8-1:0] sram_axi_wstrb,
  input  logic                sram_axi_wvalid,
  output logic                sram_axi_wready,
  output logic [1:0]          sram_axi_bresp,
  output logic                sram_axi_bvalid,
  input  logic                sram_axi_bready,
  input  logic [ADDR_W-1:0]   sram_axi_araddr,
  input  logic                sram_axi_arvalid,
  output logic                sram_axi_arready,
  output logic [DATA_W-1:0]   sram_axi_rdata,
  output logic [1:0]          sram_axi_rresp,
  output logic                sram_axi_rvalid,
  input  logic                sram_axi_rready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  function automatic logic is_oor(input logic [ADDR_W-1:0] a);
    return (a >> (LSB + IDX_W)) != '0;
  endfunction

  logic                r_run;
  logic                r_awready, r_aw_full;
  logic [ADDR_W-1:0]   r_aw_addr;
  logic                r_wready, r_w_full;
  logic [DATA_W-1:0]   r_w_data;
  logic [STRB_W-1:0]   r_w_strb;
  logic                r_bvalid, r_rvalid, r_rd_oor;
  logic [1:0]          r_bresp, r_rresp;
  grant_e              r_prio;

  logic                w_aw_hs, w_w_hs, w_aw_have, w_w_have;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;
  logic [STRB_W-1:0]   w_wr_strb;
  logic                w_wr_oor, w_rd_oor;
  logic                w_wr_elig, w_rd_elig, w_wr_gnt, w_rd_gnt;
  logic                w_aw_full_nxt, w_w_full_nxt;
  logic                w_ram_en;
  logic [STRB_W-1:0]   w_ram_we;
  logic [IDX_W-1:0]    w_ram_addr;
  logic [DATA_W-1:0]   w_ram_rdata;

  assign w_aw_hs = sram_axi_awvalid & r_awready;
  assign w_w_hs  = sram_axi_wvalid & r_wready;

  // A beat arriving this cycle counts as held, so it can be written
  // straight through without a holder round-trip (one write per cycle).
  assign w_aw_have = r_aw_full | w_aw_hs;
  assign w_w_have  = r_w_full | w_w_hs;
  assign w_wr_addr = r_aw_full ? r_aw_addr : sram_axi_awaddr;
  assign w_wr_data = r_w_full ? r_w_data : sram_axi_wdata;
  assign w_wr_strb = r_w_full ? r_w_strb : sram_axi_wstrb;
  assign w_wr_oor  = is_oor(w_wr_addr);
  assign w_rd_oor  = is_oor(sram_axi_araddr);

  assign w_wr_elig = w_aw_have & w_w_have & (~r_bvalid | sram_axi_bready);
  assign w_rd_elig = r_run & sram_axi_arvalid & (~r_rvalid | sram_axi_rready);
  assign w_wr_gnt  = w_wr_elig & (~w_rd_elig | (r_prio == GRANT_WR));
  assign w_rd_gnt  = w_rd_elig & ~w_wr_gnt;

  // A granted beat leaves its holder empty whether it came from the holder
  // or bypassed it; an ungranted new beat is parked.
  assign w_aw_full_nxt = w_wr_gnt ? 1'b0 : w_aw_have;
  assign w_w_full_nxt  = w_wr_gnt ? 1'b0 : w_w_have;

  // Out-of-range writes must not touch memory, nor disturb the read register.
  assign w_ram_en   = w_rd_gnt | (w_wr_gnt & ~w_wr_oor);
  assign w_ram_we   = (w_wr_gnt && !w_wr_oor) ? w_wr_strb : '0;
  assign w_ram_addr = w_wr_gnt ? w_wr_addr[LSB +: IDX_W] : sram_axi_araddr[LSB +: IDX_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run     <= 1'b0;
      r_awready <= 1'b0;
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_wready  <= 1'b0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rd_oor  <= 1'b0;
      r_prio    <= GRANT_WR;
    end else begin
      r_run     <= 1'b1;
      r_aw_full <= w_aw_full_nxt;
      r_awready <= ~w_aw_full_nxt;
      r_w_full  <= w_w_full_nxt;
      r_wready  <= ~w_w_full_nxt;
      if (w_aw_hs) r_aw_addr <= sram_axi_awaddr;
      if (w_w_hs) begin
        r_w_data <= sram_axi_wdata;
        r_w_strb <= sram_axi_wstrb;
      end
      if (w_wr_gnt) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_wr_oor ? RESP_SLVERR : RESP_OKAY;
      end else if (sram_axi_bready) begin
        r_bvalid <= 1'b0;
      end
      if (w_rd_gnt) begin
        r_rvalid <= 1'b1;
        r_rresp  <= w_rd_oor ? RESP_SLVERR : RESP_OKAY;
        r_rd_oor <= w_rd_oor;
      end else if (sram_axi_rready) begin
        r_rvalid <= 1'b0;
      end
      if (w_wr_gnt)      r_prio <= GRANT_RD;
      else if (w_rd_gnt) r_prio <= GRANT_WR;
    end
  end

  sp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_sp_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_wr_data),
    .o_rdata (w_ram_rdata)
  );

  assign sram_axi_awready = r_awready;
  assign sram_axi_wready  = r_wready;
  assign sram_axi_bvalid  = r_bvalid;
  assign sram_axi_bresp   = r_bresp;
  assign sram_axi_arready = w_rd_gnt;
  assign sram_axi_rvalid  = r_rvalid;
  assign sram_axi_rresp   = r_rresp;
  // The RAM read register is not reset; gating keeps rdata at 0 when idle
  // and for out-of-range reads.
  assign sram_axi_rdata   = (r_rvalid && !r_rd_oor) ? w_ram_rdata : '0;

endmodule
